// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller for the iterative (shift-add) MUL path.
// Computes the low WIDTH bits of rs1*rs2, retiring one multiplier bit per cycle,
// and raises stall_o to hold the pipeline while a multiply is in flight.
//
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero (results are unchanged, only latency shrinks).
//
// Handshake: a request is accepted on a rising edge where ready_o (IDLE),
// valid_i and !flush_i are all high; operands must stay stable while valid_i is
// high. done_o is a one-cycle pulse marking result_o valid; result_o then holds
// until the next completion. flush_i aborts any in-flight work and wins over an
// accept in the same cycle.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,     // asynchronous, active low
    input  logic             valid_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [1:0]       state_o    // FSM state, for observation only
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mp_n;
    logic             last_iter;
    logic             accept;

    // Per-iteration datapath values and the "this is the final iteration" test.
    always_comb begin
        acc_n     = mp[0] ? (acc + mc) : acc;
        mp_n      = mp >> 1;
        last_iter = (cnt == LAST_CNT);
`ifdef MUL_EARLY_EXIT_EN
        if (mp_n == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    assign accept = (state == IDLE) && valid_i && !flush_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_n = IDLE;
                end else if (last_iter) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand load on accept, shift-add iteration in BUSY, result capture on the last iteration.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mc     <= '0;
            mp     <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            mc  <= rs1_i;
            mp  <= rs2_i;
            acc <= '0;
            cnt <= '0;
        end else if ((state == BUSY) && !flush_i) begin
            acc <= acc_n;
            mc  <= mc << 1;
            mp  <= mp_n;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                result <= acc_n;
            end
        end
    end

    // Only stall_o looks at an input combinationally; everything else is decoded from registers.
    always_comb begin
        ready_o  = (state == IDLE);
        done_o   = (state == DONE);
        stall_o  = (state == BUSY) || ((state == IDLE) && valid_i);
        result_o = result;
        state_o  = state;
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl: reset values, products, back-to-back
// requests with valid held high, flush, asynchronous reset mid-operation, and
// (when MUL_EARLY_EXIT_EN is defined) early-exit latencies.
module tb_mul_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [1:0]  state_o;

    int checks = 0;
    int failures = 0;

    mul_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .state_o  (state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Expected latency for a given multiplier value.
    function automatic int exp_lat(input logic [31:0] b);
        int l;
        l = 32;
`ifdef MUL_EARLY_EXIT_EN
        l = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) l = i + 1;
        end
`endif
        return l;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request and wait (bounded) for its done pulse; returns in the DONE cycle.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res);
        int lat;
        int stall_bad;
        lat = 0;
        stall_bad = 0;
        rs1_i = a;
        rs2_i = b;
        valid_i = 1'b1;
        #1;
        check({tag, "_stall_req"}, stall_o, 1'b1);
        tick();
        valid_i = 1'b0;
        while (lat < 40) begin
            tick();
            lat++;
            if (done_o) break;
            if (stall_o !== 1'b1) stall_bad++;
        end
        check({tag, "_latency"}, lat, exp_lat(b));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_stall_busy"}, stall_bad, 0);
        check({tag, "_stall_done"}, stall_o, 1'b0);
    endtask

    initial begin
        int edge_n;
        int d1;
        int d2;
        int pulses;
        logic [31:0] flush_b;

        // Reset state
        #2;
        check("rst_ready", ready_o, 1'b1);
        check("rst_done", done_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_state", state_o, 2'd0);
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        tick();

        // 6 x 7
        run_mul("m6x7", 32'd6, 32'd7, 32'd42);
        check("m6x7_ready_in_done", ready_o, 1'b0);
        tick();
        check("m6x7_done_pulse", done_o, 1'b0);
        check("m6x7_ready_after", ready_o, 1'b1);
        repeat (3) tick();
        check("m6x7_result_hold", result_o, 32'd42);

        // Overflow wrap cases
        run_mul("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        run_mul("m80x2", 32'h8000_0000, 32'd2, 32'h0000_0000);
        tick();
        run_mul("mbig", 32'd12345, 32'd6789, 32'd83810205);
        tick();

        // valid_i held high across two requests: 6x7 then 3x5
        rs1_i = 32'd6;
        rs2_i = 32'd7;
        valid_i = 1'b1;
        tick();
        edge_n = 0;
        d1 = 0;
        d2 = 0;
        pulses = 0;
        while (edge_n < 120) begin
            tick();
            edge_n++;
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin
                    d1 = edge_n;
                    check("b2b_first_result", result_o, 32'd42);
                    rs1_i = 32'd3;
                    rs2_i = 32'd5;
                end else begin
                    d2 = edge_n;
                    check("b2b_second_result", result_o, 32'd15);
                    break;
                end
            end
        end
        valid_i = 1'b0;
        check("b2b_first_edge", d1, exp_lat(32'd7));
        check("b2b_second_edge", d2, exp_lat(32'd7) + 2 + exp_lat(32'd5));
        check("b2b_pulses", pulses, 2);
        tick();
        check("b2b_idle_ready", ready_o, 1'b1);

        // Flush at iteration 10 of 9 x 9
`ifdef MUL_EARLY_EXIT_EN
        flush_b = 32'h8000_0009;
`else
        flush_b = 32'd9;
`endif
        rs1_i = 32'd9;
        rs2_i = flush_b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", state_o, 2'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_state", state_o, 2'd0);
        check("flush_ready", ready_o, 1'b1);
        check("flush_done", done_o, 1'b0);
        check("flush_result", result_o, 32'd15);
        pulses = 0;
        repeat (30) begin
            tick();
            if (done_o) pulses++;
        end
        check("flush_no_done", pulses, 0);
        check("flush_result_hold", result_o, 32'd15);

        // Flush has priority over an accept
        rs1_i = 32'd4;
        rs2_i = 32'd4;
        valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        check("flush_vs_accept", state_o, 2'd0);
        valid_i = 1'b0;
        flush_i = 1'b0;

        // Asynchronous reset mid-BUSY
        rs1_i = 32'd5;
        rs2_i = 32'hFFFF_FFFF;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        check("arst_pre_busy", state_o, 2'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_ready", ready_o, 1'b1);
        check("arst_done", done_o, 1'b0);
        check("arst_stall", stall_o, 1'b0);
        check("arst_result", result_o, 32'h0);
        check("arst_state", state_o, 2'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        run_mul("m2x3", 32'd2, 32'd3, 32'd6);
        tick();

        // Zero multiplier
        run_mul("m7x0", 32'd7, 32'd0, 32'd0);
        tick();

`ifdef MUL_EARLY_EXIT_EN
        run_mul("ee10x3", 32'd10, 32'd3, 32'd30);
        tick();
        run_mul("ee_b31", 32'd3, 32'h8000_0001, 32'h8000_0003);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the iterative multiply path of the single-issue RV32 core. It handles ALU operation code 5 (MUL, low 32 bits of rs1×rs2) with a shift-add schedule, one multiplier bit per cycle. The decode stage uses `stall_o` to hold the pipeline while a multiply is in flight. The single-cycle ALU keeps all other operations (AND, XOR, SLL, ADD, SUB, SRAI); this block owns only the multi-cycle MUL resource.

## Interface
- `WIDTH`, default 32: operand and result width; also the iteration count.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: asynchronous, active-low reset.
- `valid_i`, input, 1: MUL request. Operands must be stable while `valid_i` is high.
- `rs1_i`, input, WIDTH: multiplicand.
- `rs2_i`, input, WIDTH: multiplier.
- `flush_i`, input, 1: abort the in-flight multiply (pipeline flush).
- `ready_o`, output, 1: block is idle and accepts a request this cycle.
- `stall_o`, output, 1: combinational pipeline hold request.
- `done_o`, output, 1: one-cycle pulse; `result_o` is valid.
- `result_o`, output, WIDTH: low WIDTH bits of rs1×rs2. Holds its value until the next completion.

## Operation
- Internal state: FSM `state` ∈ {IDLE, BUSY, DONE}, multiplicand register `mc` (WIDTH bits), multiplier register `mp` (WIDTH bits), accumulator `acc` (WIDTH bits), iteration counter `cnt` ($clog2(WIDTH)+1 bits).
- IDLE: `ready_o`=1. When `valid_i`=1 and `flush_i`=0 at an edge (the accept edge), load `mc`←rs1_i, `mp`←rs2_i, `acc`←0, `cnt`←0, and go to BUSY.
- BUSY, each edge:
  - if `mp[0]`, then `acc`←`acc`+`mc` (mod 2^WIDTH);
  - `mc`←`mc`<<1; `mp`←`mp`>>1; `cnt`←`cnt`+1;
  - when this is iteration WIDTH (`cnt`==WIDTH-1 before the increment), go to DONE and copy the next `acc` value into `result_o`.
- DONE: `done_o`=1 for exactly one cycle, then IDLE at the next edge unconditionally. A `valid_i` seen in DONE is not accepted; it is accepted from IDLE one cycle later.
- `stall_o` = (state==BUSY) | (state==IDLE & `valid_i`). It is low in DONE, so the stalled instruction advances in the same cycle `done_o` is high.
- Arithmetic: no signed handling is needed, because the low WIDTH bits are sign-agnostic. Overflow bits are discarded.
- `flush_i`=1 at any edge: state←IDLE and no `done_o` is produced. `result_o` keeps its previous value. A flush has priority over an accept in the same cycle.
- Reset, including reset mid-operation: state=IDLE, `mc`=`mp`=`acc`=0, `cnt`=0, `result_o`=0. Resulting outputs: `done_o`=0, `ready_o`=1, and `stall_o`=`valid_i`.

## Timing
- Accept at edge k. Edges k+1 … k+L perform the iterations, and DONE is entered at edge k+L. `done_o` is high in cycle (k+L, k+L+1], and IDLE is re-entered at edge k+L+1.
- Latency L = WIDTH (32) by default.
- Back-to-back requests: the next accept is possible at edge k+L+2, giving a throughput of one MUL per L+2 cycles.
- `stall_o` is combinational from `valid_i`. No other output depends combinationally on an input.

## Configuration
- `MUL_EARLY_EXIT_EN` defined: in BUSY, DONE is also entered at the first edge where the post-shift `mp` is 0. The resulting latency is L = max(1, index of the highest set bit of rs2 + 1).
  - rs2=0 gives L=1.
  - rs2=3 gives L=2.
  - rs2 with bit 31 set gives L=32.
  - Results are identical to the non-early-exit case.
- Not defined: L = WIDTH for every operand value.

## Test plan
- Reset is released; rs1=6, rs2=7, `valid_i` pulsed in IDLE. Required: `stall_o` high through BUSY, `done_o` exactly 32 cycles after the accept edge (without the macro), `result_o`=42.
- rs1=0xFFFFFFFF, rs2=0xFFFFFFFF. Required: `result_o`=0x00000001. Then rs1=0x80000000, rs2=2. Required: `result_o`=0x00000000.
- `valid_i` held high across two requests (6×7, then 3×5). Required: the second accept occurs at edge k+34, giving 42 then 15, with a `done_o` pulse for each one.
- `flush_i` asserted at iteration 10 of 9×9. Required: IDLE next edge, no `done_o`, `result_o` unchanged from the previous result, `ready_o`=1.
- `rst_i` driven low mid-BUSY. Required: all outputs return to reset values immediately, without waiting for a clock edge. After release, 2×3 completes with `result_o`=6.
- With `MUL_EARLY_EXIT_EN`:
  - rs2=3, rs1=10: `done_o` after 2 edges, `result_o`=30.
  - rs2=0: `done_o` after 1 edge, `result_o`=0.
